fc_layer: RTL and testbench
===========================

Name: fc_layer

Overview:
- Fully-connected (dense) stage directly downstream of the 2x2 max-pool stage.
- Flattens the pooled feature map row-major and computes OUT_NEURONS dot products, one neuron at a time, on a single signed MAC.
- Weights are fetched from an external synchronous weight ROM.
- Results land in a bias-added, rescaled, saturated output vector; done_fc signals completion to the classifier/top-level controller.

Parameters:
- DATA_WIDTH, 16, signed two's-complement width of activations, weights, bias and outputs.
- IN_SIZE, 14, side of the pooled ifmap (CONV_OFMAP_SIZE/2); flattened length IN_LEN = IN_SIZE*IN_SIZE.
- OUT_NEURONS, 10, number of output neurons.
- FRAC_BITS, 8, fixed-point fraction bits; the product is rescaled by an arithmetic right shift of FRAC_BITS.
- W_ADDR_WIDTH, $clog2(OUT_NEURONS*IN_LEN), weight ROM address width.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- en  in  1  start; level-sensitive, driven from done_pool.
- ifmap  in  DATA_WIDTH x [IN_SIZE][IN_SIZE]  pooled map; must stay stable while busy.
- bias  in  DATA_WIDTH x [OUT_NEURONS]  per-neuron bias, Q(FRAC_BITS) format.
- w_addr  out  W_ADDR_WIDTH  weight ROM address = neuron*IN_LEN + idx.
- w_rd  out  1  weight ROM read strobe.
- w_data  in  DATA_WIDTH  weight, valid exactly 1 cycle after w_rd.
- fc_out  out  DATA_WIDTH x [OUT_NEURONS]  neuron results.
- busy  out  1  high in LOAD, DRAIN or WRITE.
- done_fc  out  1  completion flag, registered.

Behaviour:
- Reset values: state=IDLE; neuron, idx, acc = 0; w_rd=0; w_addr=0; busy=0; done_fc=0; all fc_out entries = 0.
- IDLE: when en=1, clear neuron and idx, then go to LOAD.
- LOAD:
  - Each cycle: w_rd=1, w_addr=neuron*IN_LEN+idx, and register act = ifmap[idx/IN_SIZE][idx%IN_SIZE] (row-major flatten).
  - idx increments each cycle; at idx==IN_LEN-1, go to DRAIN.
- MAC pipeline:
  - mac_valid is w_rd delayed 1 cycle.
  - When mac_valid=1: acc += act_d * w_data, signed.
  - ACC_WIDTH = 2*DATA_WIDTH + $clog2(IN_LEN); no overflow is possible.
- DRAIN: one cycle to absorb the last product, then go to WRITE.
- WRITE:
  - sum = acc + (bias[neuron] sign-extended, shifted left by FRAC_BITS).
  - res = sum >>> FRAC_BITS.
  - Saturate res to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1] and store it in fc_out[neuron]. Clear acc.
  - If neuron==OUT_NEURONS-1, go to DONE; otherwise neuron++, idx=0, go to LOAD.
- Latency:
  - IN_LEN+2 cycles per neuron.
  - DONE is entered OUT_NEURONS*(IN_LEN+2)+1 cycles after en is sampled in IDLE.
  - done_fc rises 1 cycle after DONE is entered.
- DONE:
  - done_fc=1 while in DONE.
  - When en=0, return to IDLE; done_fc drops the next cycle.
  - fc_out holds its values until overwritten by the next run.
- en deassert mid-run is ignored; the run completes.
- en held high through DONE does not retrigger; a fresh run needs en low then high.
- Asynchronous reset mid-run aborts immediately to reset values; partial fc_out is discarded (zeroed).
- fc_out[k] updates only in the WRITE cycle for neuron k; other entries remain stable.
- Unused state encodings fall to IDLE.

Optional Feature:
- Macro FC_RELU_EN.
- Defined: in WRITE, a negative saturated result is stored as 0 (fused ReLU).
- Undefined: the signed saturated result is stored unchanged.
- Timing is identical either way.

Decomposition:
- Shared package cnn_defs:
  - fc_state_t enum {FC_IDLE, FC_LOAD, FC_DRAIN, FC_WRITE, FC_DONE}.
  - Constants FC_OUT_NEURONS, FC_FRAC_BITS, FC_ACC_WIDTH.
- Sub-module: fc_mac.
  - Registered signed multiply-accumulate with clear and valid inputs.
  - Also contains the rescale/saturate/optional-ReLU output function, so the FSM and counters stay in fc_layer.

Test Plan (IN_SIZE=2, OUT_NEURONS=3, FRAC_BITS=8, DATA_WIDTH=16 unless noted):
- Identity: ifmap = {256,512,768,1024}; neuron 0 weights = {256,0,0,0}, bias 0 -> fc_out[0]=256; done_fc rises exactly 3*(4+2)+2 = 20 cycles after en is sampled high.
- Bias and sum: all weights 256, ifmap all 256, bias[1]=128 -> fc_out[1]=1152.
- Saturation: ifmap all 32767, weights all 32767 -> fc_out = 32767; negate the weights -> -32768 (RELU off) or 0 (FC_RELU_EN).
- Handshake:
  - w_addr sequence 0..11 with w_rd continuous except one gap per DRAIN/WRITE.
  - en dropped at cycle 5 does not abort the run.
  - en held high in DONE keeps done_fc=1 with no restart.
- Reset mid-run at neuron 1 -> all outputs 0, state IDLE; a following en runs cleanly with correct results.
- Re-run: after DONE, en low then high with new ifmap -> fc_out reflects the new data; done_fc low during the run.

Source files
------------

// File: rtl/cnn_defs.sv
// Shared definitions for the CNN datapath: dense-layer FSM states and default sizing.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package cnn_defs;

    // Dense-layer controller states; encodings 5..7 are unused and recover to FC_IDLE.
    typedef enum logic [2:0] {
        FC_IDLE,
        FC_LOAD,
        FC_DRAIN,
        FC_WRITE,
        FC_DONE
    } fc_state_t;

    localparam int FC_DATA_WIDTH  = 16;
    localparam int FC_IN_SIZE     = 14;
    localparam int FC_OUT_NEURONS = 10;
    localparam int FC_FRAC_BITS   = 8;
    // Two full-width products plus enough headroom for IN_SIZE*IN_SIZE terms.
    localparam int FC_ACC_WIDTH   = 2 * FC_DATA_WIDTH + $clog2(FC_IN_SIZE * FC_IN_SIZE);

endpackage

// File: rtl/fc_layer_if.sv
// Bus bundle between the dense layer, the pool stage, the weight ROM and the classifier.
// Latency: n/a (wires only).
// Backpressure: none; w_data is expected exactly one cycle after w_rd.
interface fc_layer_if
    import cnn_defs::*;
#(
    parameter int DATA_WIDTH   = FC_DATA_WIDTH,
    parameter int IN_SIZE      = FC_IN_SIZE,
    parameter int OUT_NEURONS  = FC_OUT_NEURONS,
    parameter int W_ADDR_WIDTH = $clog2(OUT_NEURONS * IN_SIZE * IN_SIZE)
);
    logic                         en;
    logic signed [DATA_WIDTH-1:0] ifmap [IN_SIZE][IN_SIZE];
    logic signed [DATA_WIDTH-1:0] bias [OUT_NEURONS];
    logic [W_ADDR_WIDTH-1:0]      w_addr;
    logic                         w_rd;
    logic signed [DATA_WIDTH-1:0] w_data;
    logic signed [DATA_WIDTH-1:0] fc_out [OUT_NEURONS];
    logic                         busy;
    logic                         done_fc;

    // Upstream controller / ROM side.
    modport master (
        output en, ifmap, bias, w_data,
        input  w_addr, w_rd, fc_out, busy, done_fc
    );

    // Dense-layer side.
    modport slave (
        input  en, ifmap, bias, w_data,
        output w_addr, w_rd, fc_out, busy, done_fc
    );

endinterface

// File: rtl/fc_mac.sv
// Signed MAC for one neuron plus bias add, rescale, saturation and optional ReLU (FC_RELU_EN).
// Latency: acc updates 1 cycle after valid; result is combinational from the accumulator's next value.
// Backpressure: none; valid is consumed every cycle it is high.
module fc_mac
    import cnn_defs::*;
#(
    parameter int DATA_WIDTH = FC_DATA_WIDTH,
    parameter int ACC_WIDTH  = FC_ACC_WIDTH,
    parameter int FRAC_BITS  = FC_FRAC_BITS
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         clear,
    input  logic                         valid,
    input  logic signed [DATA_WIDTH-1:0] act,
    input  logic signed [DATA_WIDTH-1:0] weight,
    input  logic signed [DATA_WIDTH-1:0] bias,
    output logic signed [DATA_WIDTH-1:0] result
);
    // One extra bit so adding the shifted bias can never wrap.
    localparam int SUM_WIDTH = ACC_WIDTH + 1;

    localparam logic signed [SUM_WIDTH-1:0] SAT_MAX =
        {{(SUM_WIDTH - DATA_WIDTH + 1){1'b0}}, {(DATA_WIDTH - 1){1'b1}}};
    localparam logic signed [SUM_WIDTH-1:0] SAT_MIN =
        {{(SUM_WIDTH - DATA_WIDTH + 1){1'b1}}, {(DATA_WIDTH - 1){1'b0}}};

    logic signed [2*DATA_WIDTH-1:0] product;
    logic signed [ACC_WIDTH-1:0]    prod_ext;
    logic signed [ACC_WIDTH-1:0]    acc;
    logic signed [ACC_WIDTH-1:0]    acc_next;
    logic signed [SUM_WIDTH-1:0]    bias_ext;
    logic signed [SUM_WIDTH-1:0]    sum;
    logic signed [SUM_WIDTH-1:0]    shifted;
    logic signed [DATA_WIDTH-1:0]   sat;

    assign product  = act * weight;
    assign prod_ext = ACC_WIDTH'(product);
    // The write cycle coincides with the last product arriving, so the output
    // function works on the value the accumulator is about to take.
    assign acc_next = valid ? (acc + prod_ext) : acc;

    assign bias_ext = SUM_WIDTH'(bias) <<< FRAC_BITS;
    assign sum      = SUM_WIDTH'(acc_next) + bias_ext;
    assign shifted  = sum >>> FRAC_BITS;

    // Accumulate products; clear wins so the next neuron starts from zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc <= '0;
        end else if (clear) begin
            acc <= '0;
        end else begin
            acc <= acc_next;
        end
    end

    // Clamp the rescaled sum to the output range, then apply the optional ReLU.
    always_comb begin
        sat = shifted[DATA_WIDTH-1:0];
        if (shifted > SAT_MAX) begin
            sat = {1'b0, {(DATA_WIDTH - 1){1'b1}}};
        end else if (shifted < SAT_MIN) begin
            sat = {1'b1, {(DATA_WIDTH - 1){1'b0}}};
        end
`ifdef FC_RELU_EN
        result = sat[DATA_WIDTH-1] ? '0 : sat;
`else
        result = sat;
`endif
    end

endmodule

// File: rtl/fc_layer.sv
// Dense layer: flattens the pooled map row-major and runs OUT_NEURONS dot products on one MAC (fused ReLU under FC_RELU_EN).
// Latency: IN_LEN+2 cycles per neuron; done_fc rises one cycle after DONE is entered.
// Backpressure: none; ifmap/bias must hold while busy, the weight ROM must answer 1 cycle after w_rd.
module fc_layer
    import cnn_defs::*;
#(
    parameter int DATA_WIDTH   = FC_DATA_WIDTH,
    parameter int IN_SIZE      = FC_IN_SIZE,
    parameter int OUT_NEURONS  = FC_OUT_NEURONS,
    parameter int FRAC_BITS    = FC_FRAC_BITS,
    parameter int W_ADDR_WIDTH = $clog2(OUT_NEURONS * IN_SIZE * IN_SIZE)
) (
    input logic       clk,
    input logic       reset,
    fc_layer_if.slave bus
);
    localparam int IN_LEN    = IN_SIZE * IN_SIZE;
    localparam int ACC_WIDTH = 2 * DATA_WIDTH + $clog2(IN_LEN);
    localparam int IDX_WIDTH = (IN_LEN > 1) ? $clog2(IN_LEN) : 1;
    localparam int POS_WIDTH = (IN_SIZE > 1) ? $clog2(IN_SIZE) : 1;
    localparam int NEU_WIDTH = (OUT_NEURONS > 1) ? $clog2(OUT_NEURONS) : 1;

    localparam logic [IDX_WIDTH-1:0] IDX_LAST = IDX_WIDTH'(IN_LEN - 1);
    localparam logic [POS_WIDTH-1:0] COL_LAST = POS_WIDTH'(IN_SIZE - 1);
    localparam logic [NEU_WIDTH-1:0] NEU_LAST = NEU_WIDTH'(OUT_NEURONS - 1);

    fc_state_t                    state;
    logic [NEU_WIDTH-1:0]         neuron;
    logic [IDX_WIDTH-1:0]         idx;
    // row/col track idx/IN_SIZE and idx%IN_SIZE without a divider.
    logic [POS_WIDTH-1:0]         row;
    logic [POS_WIDTH-1:0]         col;
    // Weights are laid out neuron-major, so neuron*IN_LEN+idx is just a running count.
    logic [W_ADDR_WIDTH-1:0]      w_ptr;
    logic [W_ADDR_WIDTH-1:0]      w_addr_q;
    logic                         w_rd_q;
    logic signed [DATA_WIDTH-1:0] act;
    logic signed [DATA_WIDTH-1:0] act_d;
    logic                         mac_valid;
    logic                         busy_q;
    logic                         done_q;
    logic signed [DATA_WIDTH-1:0] fc_out_q [OUT_NEURONS];
    logic signed [DATA_WIDTH-1:0] mac_result;

    assign bus.w_addr  = w_addr_q;
    assign bus.w_rd    = w_rd_q;
    assign bus.busy    = busy_q;
    assign bus.done_fc = done_q;
    assign bus.fc_out  = fc_out_q;

    // Controller: walks idx over the flattened map per neuron, then drain, write, next neuron.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= FC_IDLE;
            neuron   <= '0;
            idx      <= '0;
            row      <= '0;
            col      <= '0;
            w_ptr    <= '0;
            w_addr_q <= '0;
            w_rd_q   <= 1'b0;
            act      <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= (state == FC_DONE);
            case (state)
                FC_IDLE: begin
                    w_rd_q <= 1'b0;
                    if (bus.en) begin
                        neuron <= '0;
                        idx    <= '0;
                        row    <= '0;
                        col    <= '0;
                        w_ptr  <= '0;
                        busy_q <= 1'b1;
                        state  <= FC_LOAD;
                    end
                end
                FC_LOAD: begin
                    w_rd_q   <= 1'b1;
                    w_addr_q <= w_ptr;
                    act      <= bus.ifmap[row][col];
                    w_ptr    <= w_ptr + W_ADDR_WIDTH'(1);
                    if (col == COL_LAST) begin
                        col <= '0;
                        row <= row + POS_WIDTH'(1);
                    end else begin
                        col <= col + POS_WIDTH'(1);
                    end
                    if (idx == IDX_LAST) begin
                        idx   <= '0;
                        row   <= '0;
                        col   <= '0;
                        state <= FC_DRAIN;
                    end else begin
                        idx <= idx + IDX_WIDTH'(1);
                    end
                end
                FC_DRAIN: begin
                    w_rd_q <= 1'b0;
                    state  <= FC_WRITE;
                end
                FC_WRITE: begin
                    w_rd_q <= 1'b0;
                    if (neuron == NEU_LAST) begin
                        busy_q <= 1'b0;
                        state  <= FC_DONE;
                    end else begin
                        neuron <= neuron + NEU_WIDTH'(1);
                        idx    <= '0;
                        state  <= FC_LOAD;
                    end
                end
                FC_DONE: begin
                    w_rd_q <= 1'b0;
                    if (!bus.en) begin
                        state <= FC_IDLE;
                    end
                end
                default: begin
                    w_rd_q <= 1'b0;
                    busy_q <= 1'b0;
                    state  <= FC_IDLE;
                end
            endcase
        end
    end

    // Align the activation with the weight that the ROM returns one cycle after w_rd.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mac_valid <= 1'b0;
            act_d     <= '0;
        end else begin
            mac_valid <= w_rd_q;
            act_d     <= act;
        end
    end

    // Only the current neuron's entry changes, and only in its WRITE cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < OUT_NEURONS; k++) begin
                fc_out_q[k] <= '0;
            end
        end else if (state == FC_WRITE) begin
            fc_out_q[neuron] <= mac_result;
        end
    end

    fc_mac #(
        .DATA_WIDTH (DATA_WIDTH),
        .ACC_WIDTH  (ACC_WIDTH),
        .FRAC_BITS  (FRAC_BITS)
    ) u_mac (
        .clk    (clk),
        .reset  (reset),
        .clear  (state == FC_WRITE),
        .valid  (mac_valid),
        .act    (act_d),
        .weight (bus.w_data),
        .bias   (bus.bias[neuron]),
        .result (mac_result)
    );

endmodule

// File: tb/tb_fc_layer.sv
// Directed bench for fc_layer on a 2x2 map with 3 neurons and a synchronous weight ROM model.
// Edge counts start at the edge that samples en, so done_fc is expected after 20 edges.
module tb_fc_layer;
    localparam int DW = 16;
    localparam int IS = 2;
    localparam int ON = 3;
    localparam int FB = 8;
    localparam int IL = IS * IS;
    localparam int AW = $clog2(ON * IL);

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    fc_layer_if #(.DATA_WIDTH(DW), .IN_SIZE(IS), .OUT_NEURONS(ON), .W_ADDR_WIDTH(AW)) bus ();

    fc_layer #(
        .DATA_WIDTH (DW),
        .IN_SIZE    (IS),
        .OUT_NEURONS(ON),
        .FRAC_BITS  (FB),
        .W_ADDR_WIDTH(AW)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    // Synchronous weight ROM: data appears one cycle after the read strobe.
    logic signed [DW-1:0] rom [0:(1<<AW)-1];
    always @(posedge clk) begin
        if (bus.w_rd) bus.w_data <= rom[bus.w_addr];
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int relu(input int v);
`ifdef FC_RELU_EN
        return (v < 0) ? 0 : v;
`else
        return v;
`endif
    endfunction

    // Read-port monitor for one run, plus a global done-while-busy watch.
    logic mon_on = 1'b0;
    logic prev_rd = 1'b0;
    int rd_cnt = 0;
    int rd_rise = 0;
    int done_busy = 0;
    int addr_log [ON*IL];
    always @(posedge clk) begin
        #1;
        if (bus.busy && bus.done_fc) done_busy++;
        if (mon_on) begin
            if (bus.w_rd) begin
                if (rd_cnt < ON * IL) addr_log[rd_cnt] = int'(bus.w_addr);
                rd_cnt++;
                if (!prev_rd) rd_rise++;
            end
            prev_rd = bus.w_rd;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_ifmap(input int a, input int b, input int c, input int d);
        bus.ifmap[0][0] = DW'(a);
        bus.ifmap[0][1] = DW'(b);
        bus.ifmap[1][0] = DW'(c);
        bus.ifmap[1][1] = DW'(d);
    endtask

    task automatic set_weights(input int n, input int w0, input int w1, input int w2, input int w3);
        rom[n*IL + 0] = DW'(w0);
        rom[n*IL + 1] = DW'(w1);
        rom[n*IL + 2] = DW'(w2);
        rom[n*IL + 3] = DW'(w3);
    endtask

    // Raise en, count edges until done_fc (bounded); optionally drop en and sample fc_out[1] mid-run.
    task automatic run(input int drop_after, input int probe_at, output int lat, output int probe);
        lat = 0;
        probe = 0;
        bus.en = 1'b1;
        while (!bus.done_fc && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
            if (lat == drop_after) bus.en = 1'b0;
            if (lat == probe_at) probe = int'(bus.fc_out[1]);
        end
    endtask

    task automatic check_outs(input string tag, input int e0, input int e1, input int e2);
        check({tag, "_out0"}, bus.fc_out[0], e0);
        check({tag, "_out1"}, bus.fc_out[1], e1);
        check({tag, "_out2"}, bus.fc_out[2], e2);
    endtask

    int lat;
    int probe;

    initial begin
        reset = 1'b1;
        bus.en = 1'b0;
        bus.w_data = '0;
        bus.bias[0] = 16'sd0;
        bus.bias[1] = 16'sd128;
        bus.bias[2] = -16'sd64;
        for (int i = 0; i < (1 << AW); i++) rom[i] = '0;
        set_ifmap(256, 512, 768, 1024);
        tick(3);

        // Reset values.
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done_fc, 0);
        check("rst_w_rd", bus.w_rd, 0);
        check("rst_w_addr", bus.w_addr, 0);
        check_outs("rst", 0, 0, 0);
        reset = 1'b0;
        tick(2);
        check("idle_busy", bus.busy, 0);

        // Run A: identity / sum+bias / negative; en dropped after 5 edges.
        set_weights(0, 256, 0, 0, 0);
        set_weights(1, 256, 256, 256, 256);
        set_weights(2, 0, 0, 0, -256);
        mon_on = 1'b1;
        run(5, 0, lat, probe);
        mon_on = 1'b0;
        check("a_latency", lat, 20);
        check_outs("a", 256, 2688, relu(-1088));
        check("a_rd_count", rd_cnt, ON * IL);
        check("a_rd_bursts", rd_rise, ON);
        for (int i = 0; i < ON * IL; i++) check($sformatf("a_addr%0d", i), addr_log[i], i);
        tick(1);
        check("a_done_drop", bus.done_fc, 0);
        tick(3);
        check_outs("a_hold", 256, 2688, relu(-1088));

        // Run B: new ifmap, en held high through DONE.
        set_ifmap(256, 256, 256, 256);
        run(0, 12, lat, probe);
        check("b_latency", lat, 20);
        check("b_out1_before_write", probe, 2688);
        check_outs("b", 256, 1152, relu(-320));
        tick(10);
        check("b_hold_done", bus.done_fc, 1);
        check("b_hold_busy", bus.busy, 0);
        check("b_hold_w_rd", bus.w_rd, 0);
        bus.en = 1'b0;
        tick(1);
        check("b_done_lag", bus.done_fc, 1);
        tick(1);
        check("b_done_drop", bus.done_fc, 0);

        // Reset in the middle of neuron 1.
        set_ifmap(32767, 32767, 32767, 32767);
        for (int n = 0; n < ON; n++) set_weights(n, 32767, 32767, 32767, 32767);
        bus.en = 1'b1;
        tick(9);
        check("mid_busy", bus.busy, 1);
        #2;
        reset = 1'b1;
        #1;
        check("mrst_busy", bus.busy, 0);
        check("mrst_w_rd", bus.w_rd, 0);
        check("mrst_w_addr", bus.w_addr, 0);
        check("mrst_done", bus.done_fc, 0);
        check_outs("mrst", 0, 0, 0);
        bus.en = 1'b0;
        tick(2);
        reset = 1'b0;
        tick(3);
        check("post_rst_busy", bus.busy, 0);
        check("post_rst_w_rd", bus.w_rd, 0);

        // Positive saturation after the aborted run.
        run(1, 0, lat, probe);
        check("sat_latency", lat, 20);
        check_outs("sat_pos", 32767, 32767, 32767);
        tick(2);

        // Negative saturation.
        for (int n = 0; n < ON; n++) set_weights(n, -32767, -32767, -32767, -32767);
        run(1, 0, lat, probe);
        check("neg_latency", lat, 20);
        check_outs("sat_neg", relu(-32768), relu(-32768), relu(-32768));
        tick(2);

        check("done_while_busy", done_busy, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
